// File: rtl/mulq_seq_ctrl.sv
// Sequencer feeding a pipelined mod-Q multiplier: captures an a-burst plus b, issues NUM_OPS jobs
// over a go/rdy handshake (operands hold while stalled), sums results mod Q, pulses dvld with dout.
module mulq_seq_ctrl #(
   parameter int NUM_OPS = 6,
   parameter int Q       = 8380417,
   parameter int W       = 24
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         soft_rstn,
   input  logic         start,
   input  logic [W-1:0] a_in,
   input  logic [W-1:0] b_in,
   input  logic         mul_rdy,
   output logic [W-1:0] mul_a,
   output logic [W-1:0] mul_b,
   output logic         mul_go,
   input  logic         mul_vld,
   input  logic [W-1:0] mul_res,
   output logic [127:0] dout,
   output logic         dvld,
   output logic         busy,
   output logic         err
);

   localparam logic [2:0]  S_IDLE    = 3'd0;
   localparam logic [2:0]  S_CAPTURE = 3'd1;
   localparam logic [2:0]  S_ISSUE   = 3'd2;
   localparam logic [2:0]  S_DRAIN   = 3'd3;
   localparam logic [2:0]  S_DONE    = 3'd4;
   localparam logic [2:0]  LAST_IDX  = 3'(NUM_OPS - 1);
   localparam logic [2:0]  N_OPS     = 3'(NUM_OPS);
   localparam logic [24:0] Q25       = 25'(Q);

   logic [2:0]   state;
   logic [2:0]   cap_cnt;
   logic [2:0]   iss_cnt;
   logic [2:0]   res_cnt;
   logic [2:0]   iss_nxt;
   logic [W-1:0] abuf [0:NUM_OPS-1];
   logic [W-1:0] b_lat;
   logic [W-1:0] r [0:3];
   logic [23:0]  acc;
   logic [23:0]  acc_nxt;
   logic [24:0]  sum;
   logic         xfer;
   logic         res_ok;
   logic         blk_rst;

   assign blk_rst = rst | ~soft_rstn;
   assign xfer    = mul_go & mul_rdy;
   assign iss_nxt = iss_cnt + 3'd1;
   assign busy    = (state != S_IDLE);
   // A result is only legal while a job is actually outstanding.
   assign res_ok  = mul_vld && (state == S_ISSUE || state == S_DRAIN) && (res_cnt < iss_cnt);

   always_comb begin
      sum     = {1'b0, acc} + 25'(mul_res);
      acc_nxt = (sum >= Q25) ? 24'(sum - Q25) : sum[23:0];
   end

   always_ff @(posedge clk) begin
      if (blk_rst) begin
         state   <= S_IDLE;
         cap_cnt <= '0;
         iss_cnt <= '0;
         res_cnt <= '0;
         acc     <= '0;
         b_lat   <= '0;
         mul_a   <= '0;
         mul_b   <= '0;
         mul_go  <= 1'b0;
         dout    <= '0;
         dvld    <= 1'b0;
         err     <= 1'b0;
         for (int i = 0; i < NUM_OPS; i++) abuf[i] <= '0;
         for (int i = 0; i < 4; i++) r[i] <= '0;
      end else begin
         dvld <= 1'b0;
         if (start && state != S_IDLE) err <= 1'b1;
         if (mul_vld && !res_ok) err <= 1'b1;

         if (res_ok) begin
            if (res_cnt < 3'd4) r[res_cnt[1:0]] <= mul_res;
            res_cnt <= res_cnt + 3'd1;
            acc     <= acc_nxt;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state   <= S_CAPTURE;
                  cap_cnt <= '0;
                  iss_cnt <= '0;
                  res_cnt <= '0;
                  acc     <= '0;
               end
            end
            S_CAPTURE: begin
               abuf[cap_cnt] <= a_in;
               if (cap_cnt == 3'd0) b_lat <= b_in;
               cap_cnt <= cap_cnt + 3'd1;
               if (cap_cnt == LAST_IDX) begin
                  state  <= S_ISSUE;
                  mul_go <= 1'b1;
                  mul_a  <= abuf[0];
                  mul_b  <= b_lat;
               end
            end
            S_ISSUE: begin
               if (xfer) begin
                  iss_cnt <= iss_nxt;
                  if (iss_cnt == LAST_IDX) begin
                     mul_go <= 1'b0;
                     state  <= S_DRAIN;
                  end else begin
                     mul_a <= abuf[iss_nxt];
                  end
               end
            end
            S_DRAIN: begin
               if (res_cnt == N_OPS) begin
                  state <= S_DONE;
                  dvld  <= 1'b1;
                  dout  <= {8'h00, acc, 24'(r[3]), 24'(r[2]), 24'(r[1]), 24'(r[0])};
               end
            end
            S_DONE:  state <= S_IDLE;
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mulq_seq_ctrl.sv
// Bench for mulq_seq_ctrl: a queue-based multiplier model with programmable latency and
// ready pattern, and a reference computing the expected result word from the burst data.
module tb_mulq_seq_ctrl;
   localparam int N = 6;
   localparam int Q = 8380417;

   logic         clk = 1'b0;
   logic         rst, soft_rstn, start, mul_rdy, mul_go, mul_vld, dvld, busy, err;
   logic [23:0]  a_in, b_in, mul_a, mul_b, mul_res;
   logic [127:0] dout;

   int n_cmp = 0;
   int n_bad = 0;
   int cyc = 0;
   int lat = 3;
   int rdy_mode = 0;
   int start_cyc, dv_cnt, dv_cyc, consumed;
   logic [127:0] dv_dat;
   int           due_q[$];
   logic [23:0]  res_q[$];
   logic [23:0]  xa_q[$];
   logic [23:0]  xb_q[$];
   logic [23:0]  cur_a[N];
   logic [23:0]  cur_b;

   mulq_seq_ctrl #(.NUM_OPS(N), .Q(Q), .W(24)) dut (
      .clk(clk), .rst(rst), .soft_rstn(soft_rstn), .start(start),
      .a_in(a_in), .b_in(b_in), .mul_rdy(mul_rdy), .mul_a(mul_a), .mul_b(mul_b),
      .mul_go(mul_go), .mul_vld(mul_vld), .mul_res(mul_res),
      .dout(dout), .dvld(dvld), .busy(busy), .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [23:0] mulq(input logic [23:0] a, input logic [23:0] b);
      longint p;
      p = longint'(a) * longint'(b);
      return 24'(p % longint'(Q));
   endfunction

   // Expected result word straight from the burst operands.
   function automatic logic [127:0] model_dout();
      longint s;
      logic [23:0] pr[N];
      s = 0;
      for (int i = 0; i < N; i++) begin
         pr[i] = mulq(cur_a[i], cur_b);
         s = (s + longint'(pr[i])) % longint'(Q);
      end
      return {8'h00, 24'(s), pr[3], pr[2], pr[1], pr[0]};
   endfunction

   task automatic tick();
      if (mul_go && mul_rdy) begin
         xa_q.push_back(mul_a);
         xb_q.push_back(mul_b);
         res_q.push_back(mulq(mul_a, mul_b));
         due_q.push_back(cyc + lat);
      end
      if (mul_vld) consumed++;
      @(posedge clk);
      #1;
      cyc++;
      if (dvld) begin
         dv_cnt++;
         dv_cyc = cyc;
         dv_dat = dout;
      end
      mul_vld = 1'b0;
      mul_res = '0;
      if (due_q.size() > 0 && due_q[0] <= cyc) begin
         void'(due_q.pop_front());
         mul_res = res_q.pop_front();
         mul_vld = 1'b1;
      end
      case (rdy_mode)
         0:       mul_rdy = 1'b1;
         1:       mul_rdy = (cyc % 3 == 0);
         default: mul_rdy = 1'($urandom_range(0, 1));
      endcase
   endtask

   task automatic do_reset();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
      due_q.delete();
      res_q.delete();
      mul_vld = 1'b0;
      dv_cnt = 0;
   endtask

   task automatic rand_job();
      cur_b = 24'($urandom_range(0, 24'hFFFFFF));
      for (int i = 0; i < N; i++) cur_a[i] = 24'($urandom_range(0, 24'hFFFFFF));
   endtask

   task automatic launch();
      xa_q.delete();
      xb_q.delete();
      dv_cnt = 0;
      consumed = 0;
      start = 1'b1;
      b_in = cur_b;
      start_cyc = cyc;
      tick();
      start = 1'b0;
      for (int k = 0; k < N; k++) begin
         a_in = cur_a[k];
         tick();
      end
      a_in = 24'($urandom);
   endtask

   task automatic wait_dv(input int budget);
      int n = 0;
      while (dv_cnt == 0 && n < budget) begin
         tick();
         n++;
      end
      if (dv_cnt == 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL dvld_timeout: no dvld within %0d cycles", budget);
      end
   endtask

   task automatic test_reset();
      logic [127:0] exp;
      rand_job();
      exp = model_dout();
      launch();
      wait_dv(60);
      n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL pre_reset_dout got %h exp %h", dout, exp); end
      start = 1'b1;
      tick();
      start = 1'b0;
      do_reset();
      n_cmp++; if (dout !== 128'h0) begin n_bad++; $display("FAIL reset_dout got %h exp 0", dout); end
      n_cmp++; if (dvld !== 1'b0) begin n_bad++; $display("FAIL reset_dvld got %b exp 0", dvld); end
      n_cmp++; if (mul_go !== 1'b0) begin n_bad++; $display("FAIL reset_mul_go got %b exp 0", mul_go); end
      n_cmp++; if (busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy got %b exp 0", busy); end
      n_cmp++; if (err !== 1'b0) begin n_bad++; $display("FAIL reset_err got %b exp 0", err); end
   endtask

   task automatic test_basic();
      logic [127:0] exp;
      do_reset();
      lat = 3;
      rdy_mode = 0;
      for (int i = 0; i < N; i++) cur_a[i] = 24'(i + 1);
      cur_b = 24'd2;
      exp = model_dout();
      launch();
      wait_dv(60);
      n_cmp++; if (dv_cyc - start_cyc !== 17) begin n_bad++; $display("FAIL basic_latency got %0d exp 17", dv_cyc - start_cyc); end
      n_cmp++; if (dv_dat[119:96] !== 24'd42) begin n_bad++; $display("FAIL basic_acc got %0d exp 42", dv_dat[119:96]); end
      n_cmp++; if (dv_dat !== exp) begin n_bad++; $display("FAIL basic_dout got %h exp %h", dv_dat, exp); end
      for (int i = 0; i < 4; i++) tick();
      n_cmp++; if (dv_cnt !== 1) begin n_bad++; $display("FAIL basic_pulses got %0d exp 1", dv_cnt); end
      n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL basic_dout_hold got %h exp %h", dout, exp); end
      n_cmp++; if (busy !== 1'b0 || err !== 1'b0) begin n_bad++; $display("FAIL basic_idle got busy=%b err=%b exp 0 0", busy, err); end
   endtask

   task automatic test_wrap();
      logic [127:0] exp;
      do_reset();
      lat = $urandom_range(1, 5);
      rdy_mode = 0;
      for (int i = 0; i < N; i++) cur_a[i] = 24'(Q - 1);
      cur_b = 24'd1;
      exp = model_dout();
      launch();
      wait_dv(60);
      n_cmp++; if (dv_dat[119:96] !== 24'd8380411) begin n_bad++; $display("FAIL wrap_acc got %0d exp 8380411", dv_dat[119:96]); end
      n_cmp++; if (dv_dat !== exp) begin n_bad++; $display("FAIL wrap_dout got %h exp %h", dv_dat, exp); end
   endtask

   task automatic test_stall();
      logic [127:0] exp;
      logic pg, pr;
      logic [23:0] pa, pb;
      int hold_bad, ops_bad, n;
      for (int it = 0; it < 4; it++) begin
         do_reset();
         rdy_mode = (it == 0) ? 1 : 2;
         lat = $urandom_range(1, 4);
         rand_job();
         exp = model_dout();
         launch();
         hold_bad = 0;
         n = 0;
         while (dv_cnt == 0 && n < 200) begin
            pg = mul_go; pr = mul_rdy; pa = mul_a; pb = mul_b;
            tick();
            n++;
            if (pg && !pr && !(mul_go === 1'b1 && mul_a === pa && mul_b === pb)) hold_bad++;
         end
         n_cmp++; if (dv_cnt !== 1) begin n_bad++; $display("FAIL stall_done it=%0d got %0d pulses exp 1", it, dv_cnt); end
         n_cmp++; if (hold_bad !== 0) begin n_bad++; $display("FAIL stall_hold it=%0d got %0d violations exp 0", it, hold_bad); end
         n_cmp++; if (xa_q.size() !== N) begin n_bad++; $display("FAIL stall_xfers it=%0d got %0d exp %0d", it, xa_q.size(), N); end
         ops_bad = 0;
         for (int i = 0; i < N && i < xa_q.size(); i++)
            if (xa_q[i] !== cur_a[i] || xb_q[i] !== cur_b) ops_bad++;
         n_cmp++; if (ops_bad !== 0) begin n_bad++; $display("FAIL stall_operands it=%0d got %0d wrong exp 0", it, ops_bad); end
         n_cmp++; if (dv_dat !== exp) begin n_bad++; $display("FAIL stall_dout it=%0d got %h exp %h", it, dv_dat, exp); end
      end
      rdy_mode = 0;
   endtask

   task automatic test_busy_start();
      logic [127:0] exp;
      int n;
      do_reset();
      lat = 2;
      rand_job();
      exp = model_dout();
      launch();
      n = 0;
      while (mul_go !== 1'b1 && n < 20) begin tick(); n++; end
      start = 1'b1;
      b_in = ~cur_b;
      tick();
      start = 1'b0;
      wait_dv(60);
      for (int i = 0; i < 20; i++) tick();
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL busy_start_err got %b exp 1", err); end
      n_cmp++; if (dv_dat !== exp) begin n_bad++; $display("FAIL busy_start_dout got %h exp %h", dv_dat, exp); end
      n_cmp++; if (dv_cnt !== 1 || busy !== 1'b0) begin n_bad++; $display("FAIL busy_start_single got pulses=%0d busy=%b exp 1 0", dv_cnt, busy); end
      do_reset();
      mul_vld = 1'b1;
      mul_res = 24'd5;
      tick();
      tick();
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL spurious_vld_err got %b exp 1", err); end
      n_cmp++; if (busy !== 1'b0 || dv_cnt !== 0) begin n_bad++; $display("FAIL spurious_vld_idle got busy=%b pulses=%0d exp 0 0", busy, dv_cnt); end
   endtask

   task automatic test_soft_reset();
      logic [127:0] exp;
      int n;
      do_reset();
      lat = 6;
      rdy_mode = 0;
      rand_job();
      launch();
      n = 0;
      while (!(consumed >= 4 && xa_q.size() == N) && n < 60) begin tick(); n++; end
      soft_rstn = 1'b0;
      tick();
      soft_rstn = 1'b1;
      n_cmp++; if (busy !== 1'b0 || mul_go !== 1'b0 || dvld !== 1'b0) begin n_bad++; $display("FAIL soft_reset_idle got busy=%b go=%b dvld=%b exp 0 0 0", busy, mul_go, dvld); end
      for (int i = 0; i < 12; i++) tick();
      n_cmp++; if (dv_cnt !== 0) begin n_bad++; $display("FAIL soft_reset_no_dvld got %0d exp 0", dv_cnt); end
      n_cmp++; if (err !== 1'b1) begin n_bad++; $display("FAIL soft_reset_late_err got %b exp 1", err); end
      lat = 2;
      rand_job();
      exp = model_dout();
      launch();
      wait_dv(60);
      n_cmp++; if (dv_dat !== exp) begin n_bad++; $display("FAIL soft_reset_clean got %h exp %h", dv_dat, exp); end
   endtask

   task automatic test_back_to_back();
      logic [127:0] exp;
      do_reset();
      lat = $urandom_range(1, 4);
      rand_job();
      exp = model_dout();
      launch();
      wait_dv(60);
      start = 1'b1;
      tick();
      start = 1'b0;
      n_cmp++; if (busy !== 1'b0 || err !== 1'b1) begin n_bad++; $display("FAIL done_start got busy=%b err=%b exp 0 1", busy, err); end
      n_cmp++; if (dout !== exp) begin n_bad++; $display("FAIL done_start_dout got %h exp %h", dout, exp); end
      rand_job();
      exp = model_dout();
      launch();
      wait_dv(60);
      n_cmp++; if (dv_dat !== exp) begin n_bad++; $display("FAIL back_to_back_dout got %h exp %h", dv_dat, exp); end
   endtask

   initial begin
      rst = 1'b1; soft_rstn = 1'b1; start = 1'b0;
      a_in = '0; b_in = '0; mul_rdy = 1'b1; mul_vld = 1'b0; mul_res = '0;
      dv_cnt = 0; dv_cyc = 0; dv_dat = '0; consumed = 0; start_cyc = 0;
      do_reset();
      test_reset();
      test_basic();
      test_wrap();
      test_stall();
      test_busy_start();
      test_soft_reset();
      test_back_to_back();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
